noc_sink_ep: RTL and testbench
==============================

Name: noc_sink_ep

Overview:
- Receive-side network endpoint: the consumer that pairs with a traffic-generating PE. It accepts flits from a NoC output port and buffers them per virtual channel (VC).
- It drains flits through a ready/valid output port and returns one credit upstream for every buffer slot freed.
- It counts flits and packets received and flags protocol violations, so testbenches can check end-to-end delivery.

Parameters:
- NUM_VCS, 2, number of virtual channels.
- FLIT_DATA_WIDTH, 32, width of the flit payload.
- DEST_BITS, 4, width of the destination field.
- BUF_DEPTH, 4, flit slots per VC FIFO. Must equal the upstream initial credit count.
- MY_ID, 10, receive-port ID of this endpoint.
- Derived: VC_BITS = (NUM_VCS>1) ? clog2(NUM_VCS) : 1.
- Derived: FW = 2+DEST_BITS+VC_BITS+FLIT_DATA_WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  enables drain and credit return.
- flit_in  in  FW  {valid, tail, dest, vc, data}, MSB first.
- credit_out  out  1+VC_BITS  {valid, vc}.
- out_valid  out  1  output register holds a flit.
- out_ready  in  1  consumer accepts the flit.
- out_data  out  FLIT_DATA_WIDTH  flit payload.
- out_vc  out  VC_BITS  VC the flit arrived on.
- out_dest  out  DEST_BITS  destination field of the flit.
- out_tail  out  1  tail bit of the flit.
- flit_count  out  16  flits accepted on the output port; wraps.
- pkt_count  out  16  tail flits accepted on the output port; wraps.
- err_flags  out  3  sticky flags: [0] overflow, [1] misroute, [2] bad VC.

Behaviour:
- Reset (async, rst=1):
  - All FIFOs empty.
  - out_valid=0; out_data, out_vc, out_dest, out_tail=0.
  - credit_out=0; counters=0; err_flags=0.
  - rr_last=NUM_VCS-1, so VC0 is served first.
  - Reset mid-operation discards all buffered flits and sends no credits for them.
- Enqueue (every cycle, regardless of en), when flit_in[FW-1]=1:
  - vc >= NUM_VCS: drop the flit, set err_flags[2].
  - Target FIFO full and not popped this cycle: drop the flit, set err_flags[0].
  - Otherwise write the flit (tail, dest, data) into FIFO[vc] at the clock edge.
  - Full FIFO popped in the same cycle: the write is accepted.
  - dest != MY_ID: the flit is still enqueued and delivered; set err_flags[1].
- Output register load:
  - Condition: en=1, and (out_valid=0 or out_ready=1), and at least one FIFO non-empty.
  - Select the first non-empty VC scanning rr_last+1, rr_last+2, … modulo NUM_VCS.
  - Pop that FIFO head into the output register; set out_valid=1; rr_last := selected VC.
  - Same edge: credit_out := {1, selected VC}.
- Output hold and clear:
  - Without a load, credit_out := 0. At most one credit per cycle.
  - out_valid=1 and out_ready=0: all out_* held stable.
  - out_ready=1 with no load: out_valid := 0.
- Acceptance (out_valid and out_ready at an edge):
  - flit_count += 1.
  - pkt_count += 1 if out_tail=1.
- en=0:
  - No loads; credit_out=0 from the next edge.
  - An existing out_valid flit still completes its handshake.
  - FIFO writes continue.
- Latency:
  - Flit valid on flit_in in cycle N, output idle → out_valid and credit_out valid in cycle N+2.
  - Back-to-back throughput: 1 flit/cycle with out_ready=1.
- Ordering: FIFO order within a VC; round-robin between VCs.
- Total buffering per VC = BUF_DEPTH. The output register slot has already been credited back.

Test Plan:
- Single flit, MY_ID=10:
  - Stimulus: cycle 5, flit_in = {1,0,dest=10,vc=0,'hdead0}; out_ready=1.
  - Response: cycle 7 out_valid=1, out_data='hdead0, credit_out={1,0}; cycle 8 flit_count=1, pkt_count=0, err_flags=0.
- Backpressure and overflow:
  - Stimulus: out_ready=0; 5 consecutive flits on VC0 ('hdead0..'hdead4).
  - Response: exactly one credit {1,0}; out_data stays 'hdead0.
  - Stimulus: a 6th flit.
  - Response: err_flags[0]=1, flit dropped.
  - Stimulus: raise out_ready.
  - Response: 'hdead0..'hdead4 delivered in order, 4 further credits, flit_count=5.
- Round-robin:
  - Stimulus: VC0 holds A0,A1; VC1 holds B0,B1; then en=1, out_ready=1.
  - Response: output order A0,B0,A1,B1; credit VCs 0,1,0,1.
- Packet count:
  - Stimulus: 3-flit packet on VC1 with tail only on flit 3.
  - Response: pkt_count goes 0→1 only at acceptance of flit 3; flit_count=3.
- Misroute / bad VC:
  - Stimulus: flit with dest=3.
  - Response: flit delivered, err_flags=3'b010.
  - Stimulus: with NUM_VCS=3, flit with vc=3.
  - Response: dropped, err_flags[2]=1, no credit.
- Reset mid-operation and enable:
  - Stimulus: 3 flits buffered with out_ready=0; pulse rst.
  - Response: out_valid=0, credit_out=0, counters and err_flags 0, no credits follow.
  - Stimulus: en=0 while sending 2 flits.
  - Response: no output, no credits. After en=1, both are delivered and credited.

Source files
------------

// File: rtl/noc_sink_ep.sv
// Receive-side NoC endpoint: per-VC flit FIFOs drained round-robin into a
// ready/valid output register, with credit return and delivery statistics.

module noc_sink_vc_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + PW'(1);
  endfunction

  assign rdata = mem[rd_ptr];
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);

  // Storage needs no reset: cnt alone decides what is valid.
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wdata;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= inc(wr_ptr);
      if (pop)  rd_ptr <= inc(rd_ptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
endmodule

module noc_sink_ep #(
  parameter int NUM_VCS         = 2,
  parameter int FLIT_DATA_WIDTH = 32,
  parameter int DEST_BITS       = 4,
  parameter int BUF_DEPTH       = 4,
  parameter int MY_ID           = 10,
  parameter int VC_BITS         = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
  parameter int FW              = 2 + DEST_BITS + VC_BITS + FLIT_DATA_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [FW-1:0]              flit_in,
  output logic [VC_BITS:0]           credit_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [FLIT_DATA_WIDTH-1:0] out_data,
  output logic [VC_BITS-1:0]         out_vc,
  output logic [DEST_BITS-1:0]       out_dest,
  output logic                       out_tail,
  output logic [15:0]                flit_count,
  output logic [15:0]                pkt_count,
  output logic [2:0]                 err_flags
);
  typedef struct packed {
    logic                       valid;
    logic                       tail;
    logic [DEST_BITS-1:0]       dest;
    logic [VC_BITS-1:0]         vc;
    logic [FLIT_DATA_WIDTH-1:0] data;
  } flit_t;

  typedef struct packed {
    logic                       tail;
    logic [DEST_BITS-1:0]       dest;
    logic [FLIT_DATA_WIDTH-1:0] data;
  } entry_t;

  localparam int EW = $bits(entry_t);

  flit_t                  fin;
  entry_t                 wentry, sel_entry;
  entry_t [NUM_VCS-1:0]   heads;
  logic   [NUM_VCS-1:0]   push, pop, full, empty;
  logic   [VC_BITS-1:0]   rr_last, sel;
  logic                   found, load, overflow, bad_vc, misroute, accept;

  assign fin    = flit_in;
  assign wentry = '{tail: fin.tail, dest: fin.dest, data: fin.data};

  for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
    noc_sink_vc_fifo #(.DEPTH(BUF_DEPTH), .W(EW)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[v]),
      .pop   (pop[v]),
      .wdata (wentry),
      .rdata (heads[v]),
      .full  (full[v]),
      .empty (empty[v])
    );
  end

  // Enqueue runs independently of en; a full FIFO popped this cycle still takes the write.
  always_comb begin
    push     = '0;
    overflow = 1'b0;
    for (int v = 0; v < NUM_VCS; v++)
      if (fin.valid && int'(fin.vc) == v) begin
        if (full[v] && !pop[v]) overflow = 1'b1;
        else                    push[v]  = 1'b1;
      end
  end

  assign bad_vc   = fin.valid && (int'(fin.vc) >= NUM_VCS);
  assign misroute = (|push) && (fin.dest != DEST_BITS'(MY_ID));

  // Round-robin: first non-empty VC after the one served last.
  always_comb begin
    found = 1'b0;
    sel   = rr_last;
    for (int k = 1; k <= NUM_VCS; k++)
      for (int v = 0; v < NUM_VCS; v++)
        if (!found && !empty[v] && v == (int'(rr_last) + k) % NUM_VCS) begin
          found = 1'b1;
          sel   = VC_BITS'(v);
        end
  end

  assign load   = en && (!out_valid || out_ready) && found;
  assign accept = out_valid && out_ready;

  always_comb begin
    pop       = '0;
    sel_entry = '0;
    for (int v = 0; v < NUM_VCS; v++)
      if (load && int'(sel) == v) begin
        pop[v]    = 1'b1;
        sel_entry = heads[v];
      end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_vc     <= '0;
      out_dest   <= '0;
      out_tail   <= 1'b0;
      credit_out <= '0;
      rr_last    <= VC_BITS'(NUM_VCS - 1);
      flit_count <= '0;
      pkt_count  <= '0;
      err_flags  <= '0;
    end else begin
      credit_out <= load ? {1'b1, sel} : '0;
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= sel_entry.data;
        out_vc    <= sel;
        out_dest  <= sel_entry.dest;
        out_tail  <= sel_entry.tail;
        rr_last   <= sel;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        flit_count <= flit_count + 16'd1;
        if (out_tail) pkt_count <= pkt_count + 16'd1;
      end
      err_flags <= err_flags | {bad_vc, misroute, overflow};
    end
endmodule

// File: tb/tb_noc_sink_ep.sv
// Directed bench for noc_sink_ep: a 2-VC instance for the main flows and a
// 3-VC instance to reach the out-of-range VC case.

module tb_noc_sink_ep;
  localparam int FW  = 39;
  localparam int FW3 = 40;

  logic            clk, rst, en, out_ready;
  logic [FW-1:0]   flit_in;
  logic [1:0]      credit_out;
  logic            out_valid, out_tail;
  logic [31:0]     out_data;
  logic            out_vc;
  logic [3:0]      out_dest;
  logic [15:0]     flit_count, pkt_count;
  logic [2:0]      err_flags;

  logic            en3, out_ready3;
  logic [FW3-1:0]  flit3;
  logic [2:0]      credit3;
  logic            out_valid3, out_tail3;
  logic [31:0]     out_data3;
  logic [1:0]      out_vc3;
  logic [3:0]      out_dest3;
  logic [15:0]     flit_count3, pkt_count3;
  logic [2:0]      err3;

  int errors = 0;
  int checks = 0;

  logic [31:0] got_d[$];
  logic        got_v[$];
  logic        cr_v[$];
  logic [31:0] got3[$];
  int          cr3_n;

  noc_sink_ep dut (
    .clk(clk), .rst(rst), .en(en), .flit_in(flit_in), .credit_out(credit_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_vc(out_vc),
    .out_dest(out_dest), .out_tail(out_tail), .flit_count(flit_count),
    .pkt_count(pkt_count), .err_flags(err_flags)
  );

  noc_sink_ep #(.NUM_VCS(3)) dut3 (
    .clk(clk), .rst(rst), .en(en3), .flit_in(flit3), .credit_out(credit3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3), .out_vc(out_vc3),
    .out_dest(out_dest3), .out_tail(out_tail3), .flit_count(flit_count3),
    .pkt_count(pkt_count3), .err_flags(err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk(input logic t, input logic [3:0] d, input logic v,
                                       input logic [31:0] x);
    return {1'b1, t, d, v, x};
  endfunction

  task automatic step();
    if (out_valid && out_ready) begin
      got_d.push_back(out_data);
      got_v.push_back(out_vc);
    end
    if (out_valid3 && out_ready3) got3.push_back(out_data3);
    @(posedge clk); #1;
    if (credit_out[1]) cr_v.push_back(credit_out[0]);
    if (credit3[2]) cr3_n++;
  endtask

  task automatic clr();
    got_d.delete(); got_v.delete(); cr_v.delete(); got3.delete();
    cr3_n = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clr();
  endtask

  initial begin
    logic [31:0] rr_d [4];
    logic        rr_v [4];

    rst = 1'b1; en = 1'b1; out_ready = 1'b1; flit_in = '0;
    en3 = 1'b1; out_ready3 = 1'b1; flit3 = '0;
    clr();
    @(posedge clk); #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_credit", credit_out, 0);
    chk("rst_flit_count", flit_count, 0);
    chk("rst_pkt_count", pkt_count, 0);
    chk("rst_err", err_flags, 0);
    rst = 1'b0;

    // single flit: visible two cycles after it is presented
    flit_in = mk(0, 4'd10, 0, 32'hdead0);
    step();
    flit_in = '0;
    chk("single_n1_valid", out_valid, 0);
    step();
    chk("single_valid", out_valid, 1);
    chk("single_data", out_data, 32'hdead0);
    chk("single_credit", credit_out, 2'b10);
    step();
    chk("single_flit_count", flit_count, 1);
    chk("single_pkt_count", pkt_count, 0);
    chk("single_err", err_flags, 0);
    chk("single_credit_clear", credit_out, 0);

    // backpressure, then overflow of a full VC0 FIFO
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      flit_in = mk(0, 4'd10, 0, 32'hdead0 + i);
      step();
    end
    flit_in = mk(0, 4'd10, 0, 32'hdead5);
    step();
    flit_in = '0;
    chk("bp_credits", cr_v.size(), 1);
    chk("bp_credit_vc", cr_v[0], 0);
    chk("bp_hold_data", out_data, 32'hdead0);
    chk("bp_hold_valid", out_valid, 1);
    chk("ovf_err", err_flags, 3'b001);
    out_ready = 1'b1;
    repeat (7) step();
    chk("bp_delivered", got_d.size(), 5);
    for (int i = 0; i < 5; i++) chk("bp_order", got_d[i], 32'hdead0 + i);
    chk("bp_total_credits", cr_v.size(), 5);
    chk("bp_flit_count", flit_count, 5);

    // round-robin between VCs
    do_reset();
    en = 1'b0;
    flit_in = mk(0, 4'd10, 0, 32'ha0); step();
    flit_in = mk(0, 4'd10, 0, 32'ha1); step();
    flit_in = mk(0, 4'd10, 1, 32'hb0); step();
    flit_in = mk(0, 4'd10, 1, 32'hb1); step();
    flit_in = '0;
    step();
    chk("rr_en0_credits", cr_v.size(), 0);
    chk("rr_en0_valid", out_valid, 0);
    en = 1'b1;
    repeat (7) step();
    rr_d = '{32'ha0, 32'hb0, 32'ha1, 32'hb1};
    rr_v = '{1'b0, 1'b1, 1'b0, 1'b1};
    chk("rr_count", got_d.size(), 4);
    chk("rr_credit_count", cr_v.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("rr_data", got_d[i], rr_d[i]);
      chk("rr_vc", got_v[i], rr_v[i]);
      chk("rr_credit_vc", cr_v[i], rr_v[i]);
    end

    // packet counting on VC1: tail only on the third flit
    do_reset();
    flit_in = mk(0, 4'd10, 1, 32'hc0); step();
    flit_in = mk(0, 4'd10, 1, 32'hc1); step();
    flit_in = mk(1, 4'd10, 1, 32'hc2); step();
    flit_in = '0;
    step();
    chk("pkt_before_tail", pkt_count, 0);
    chk("pkt_flits_2", flit_count, 2);
    step();
    chk("pkt_after_tail", pkt_count, 1);
    chk("pkt_flits_3", flit_count, 3);
    chk("pkt_err", err_flags, 0);

    // misroute on the 2-VC instance; bad VC then a legal VC2 flit on the 3-VC instance
    do_reset();
    flit_in = mk(0, 4'd3, 0, 32'h33);
    flit3   = {1'b1, 1'b0, 4'd10, 2'd3, 32'hbad};
    step();
    flit_in = '0;
    flit3   = {1'b1, 1'b0, 4'd10, 2'd2, 32'h22};
    step();
    flit3   = '0;
    repeat (4) step();
    chk("misroute_delivered", got_d.size(), 1);
    chk("misroute_data", got_d[0], 32'h33);
    chk("misroute_dest", out_dest, 4'd3);
    chk("misroute_err", err_flags, 3'b010);
    chk("badvc_err", err3, 3'b100);
    chk("badvc_credits", cr3_n, 1);
    chk("badvc_delivered", got3.size(), 1);
    chk("vc2_data", got3[0], 32'h22);
    chk("vc2_vc", out_vc3, 2'd2);

    // reset mid-operation discards buffered flits
    do_reset();
    out_ready = 1'b0;
    flit_in = mk(0, 4'd10, 0, 32'hd0); step();
    flit_in = mk(0, 4'd3,  0, 32'hd1); step();
    flit_in = mk(0, 4'd10, 0, 32'hd2); step();
    flit_in = '0;
    chk("mid_err_before", err_flags, 3'b010);
    chk("mid_valid_before", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_credit", credit_out, 0);
    chk("mid_rst_err", err_flags, 0);
    chk("mid_rst_count", flit_count, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    clr();
    out_ready = 1'b1;
    repeat (5) step();
    chk("mid_no_credits", cr_v.size(), 0);
    chk("mid_no_output", got_d.size(), 0);

    // en=0 holds back delivery and credits but keeps buffering
    en = 1'b0;
    flit_in = mk(0, 4'd10, 1, 32'he0); step();
    flit_in = mk(0, 4'd10, 1, 32'he1); step();
    flit_in = '0;
    repeat (3) step();
    chk("en0_credits", cr_v.size(), 0);
    chk("en0_valid", out_valid, 0);
    en = 1'b1;
    repeat (5) step();
    chk("en1_delivered", got_d.size(), 2);
    chk("en1_first", got_d[0], 32'he0);
    chk("en1_second", got_d[1], 32'he1);
    chk("en1_credits", cr_v.size(), 2);
    chk("en1_flit_count", flit_count, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
